riscv_multicycle_control: RTL and testbench
===========================================

# riscv_multicycle_control

Multicycle control unit for the simple RISC-V datapath. It fetches each instruction through a request/valid handshake, decodes it, and drives the datapath control strobes (`loadPC`, `PCSrc`, `ALUSrc`, `RegWrite`, `MemtoReg`, `ALUCtrl`) one state at a time. It waits on data memory with a request/ready handshake. It sits between the instruction/data memories and the datapath, one level below the processor top.

## Interface
Parameters:
- `INSTR_RESET`, default `32'h00000013` (addi x0,x0,0): IR value loaded at reset.

Ports:
- `clk`  in  1  global clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `instruction`  in  32  instruction memory data; sampled only when `iValid` is high in FETCH.
- `iValid`  in  1  instruction memory data valid.
- `dReady`  in  1  data memory access complete.
- `Zero`  in  1  ALU zero flag from the datapath.
- `iReq`  out  1  instruction fetch request.
- `MemRead`  out  1  data memory read strobe.
- `MemWrite`  out  1  data memory write strobe.
- `loadPC`  out  1  PC update enable.
- `PCSrc`  out  1  PC source: 1 selects the branch target.
- `ALUSrc`  out  1  ALU operand B source: 1 selects the immediate.
- `RegWrite`  out  1  register file write enable.
- `MemtoReg`  out  1  writeback source: 1 selects memory read data.
- `ALUCtrl`  out  4  ALU operation code.
- `IllegalInstr`  out  1  sticky flag for an illegal instruction.
- `ctrlState`  out  3  current FSM state, for debug.

## Operation
- **States:**
  - FETCH = 0
  - DECODE = 1
  - EXECUTE = 2
  - MEM = 3
  - ERROR = 7
- **IR:** a 32-bit register loaded from `instruction` when the FSM is in FETCH and `iValid` is high. All decode uses IR only.
- **ALUCtrl encoding:**
  - AND = 0000, OR = 0001, ADD = 0010, SUB = 0110
  - SLT = 0111, SRL = 1000, SLL = 1001, SRA = 1010, XOR = 1101
- **Opcodes supported:**
  - R-type 0110011, I-ALU 0010011
  - LW 0000011 (funct3 = 010), SW 0100011 (funct3 = 010)
  - BEQ/BNE 1100011 (funct3 = 000 / 001)
- **Illegal instructions:** any other opcode or funct3; R-type with funct7 other than 0000000 or 0100000; SUB/SRA bit set on any funct3 other than 000/101.
- **ALUCtrl decode (combinational from IR):**
  - R-type: funct3 selects the operation; IR[30] selects SUB/SRA.
  - I-ALU: same mapping, except funct3 = 000 is always ADD.
  - LW/SW: ADD.
  - Branch: SUB.
- **ALUSrc:** 1 for I-ALU, LW and SW; 0 otherwise.
- **MemtoReg:** 1 for LW; 0 otherwise.
- **Transitions and strobes:**
  - FETCH: `iReq` = 1. Stay until `iValid` = 1, then capture IR and go to DECODE.
  - DECODE: no strobes. Illegal instruction: set `IllegalInstr`, go to ERROR. Otherwise go to EXECUTE.
  - EXECUTE, R-type or I-ALU: `RegWrite` = 1, `loadPC` = 1, go to FETCH.
  - EXECUTE, branch: `loadPC` = 1. `PCSrc` = `Zero` for BEQ, `!Zero` for BNE. Go to FETCH.
  - EXECUTE, LW/SW: go to MEM.
  - MEM, LW: `MemRead` = 1 until `dReady`. In the `dReady` cycle, also `RegWrite` = 1 and `loadPC` = 1; go to FETCH.
  - MEM, SW: `MemWrite` = 1 until `dReady`. In the `dReady` cycle, also `loadPC` = 1; go to FETCH.
  - ERROR: all strobes 0. The only exit is reset.
- **Strobe defaults:** `iReq`, `MemRead`, `MemWrite`, `loadPC`, `RegWrite` and `PCSrc` are 0 outside the cases listed above.
- `iValid` outside FETCH and `dReady` outside MEM are ignored.

## Timing
- **Reset (asynchronous assertion):**
  - State = FETCH, IR = `INSTR_RESET`, `IllegalInstr` = 0.
  - Outputs: `iReq` = 1, `ALUCtrl` = 0010, `ALUSrc` = 1, all other outputs 0.
- Reset asserted mid-instruction aborts the instruction immediately: no `RegWrite`, `loadPC` or memory strobe follows.
- Deassertion is synchronised externally; the first edge after deassertion may capture IR if `iValid` is high.
- **Latency, with zero memory wait:**
  - ALU instructions and branches: 3 cycles.
  - LW/SW: 4 cycles.
  - Each FETCH or MEM wait cycle adds 1.
- `loadPC` is high for exactly one cycle per retired instruction.
- `MemRead` and `MemWrite` are never high together.
- `RegWrite` and `MemWrite` are never high together.

## Configuration
- Macro: `RETIRE_COUNT_EN`.
- **Defined:** adds output port `instret` (32 bits).
  - Reset value 0.
  - Increments on every edge where `loadPC` = 1.
  - Wraps from 0xFFFFFFFF to 0.
- **Undefined:** the port and the counter are absent; all other behaviour is identical.

## Test plan
- **Reset:** hold `rst` = 0, then release; `iValid` = 1 with 0x00500093 (addi x1,x0,5). Expect reset outputs per Timing; DECODE next cycle; EXECUTE with `ALUCtrl` = 0010, `ALUSrc` = 1, `RegWrite` = 1, `loadPC` = 1; back to FETCH; 3 cycles total.
- **R-type:** 0x002081B3 (add x3,x1,x2). Expect `ALUCtrl` = 0010, `ALUSrc` = 0. Then 0x402081B3 (sub). Expect `ALUCtrl` = 0110.
- **Load:** 0x0040A283 (lw x5,4(x1)) with `dReady` delayed 2 cycles. Expect `MemRead` high for 3 cycles; `RegWrite` = `MemtoReg` = `loadPC` = 1 only in the `dReady` cycle; 6 cycles total. Repeat with 0x0020A423 (sw). Expect `MemWrite` high for 3 cycles and `RegWrite` never high.
- **Branch:** 0x00208463 (beq) with `Zero` = 1. Expect `PCSrc` = 1, `loadPC` = 1. Repeat with `Zero` = 0. Expect `PCSrc` = 0. Repeat with the BNE encoding 0x00209463. Expect the inverse.
- **Illegal instruction:** 0xFFFFFFFF. Expect `IllegalInstr` = 1 and `ctrlState` = 7; all strobes stay 0 for 10 cycles; `rst` pulse clears the flag and returns to FETCH.
- **Reset mid-operation:** assert `rst` while in MEM with `MemRead` = 1. Expect `MemRead` to drop the same cycle and no `RegWrite` or `loadPC`. With `RETIRE_COUNT_EN` defined, `instret` returns to 0.

Source files
------------

// File: rtl/riscv_multicycle_control.sv
// riscv_multicycle_control: FETCH/DECODE/EXECUTE/MEM control FSM for the
// simple RISC-V datapath.
// Ports: clk, rst (async, active-low); instruction/iValid/iReq fetch handshake;
//   dReady/MemRead/MemWrite data handshake; Zero from the ALU; datapath strobes
//   loadPC, PCSrc, ALUSrc, RegWrite, MemtoReg, ALUCtrl[3:0]; sticky IllegalInstr;
//   ctrlState[2:0] for debug.
// Optional: define RETIRE_COUNT_EN to add the 32-bit instret retire counter.
module riscv_multicycle_control #(
    parameter logic [31:0] INSTR_RESET = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        iValid,
    input  logic        dReady,
    input  logic        Zero,
    output logic        iReq,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        loadPC,
    output logic        PCSrc,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic [3:0]  ALUCtrl,
    output logic        IllegalInstr,
`ifdef RETIRE_COUNT_EN
    output logic [31:0] instret,
`endif
    output logic [2:0]  ctrlState
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_ERROR   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    state_t      state;
    state_t      state_n;
    logic [31:0] ir;
    logic        illegal_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_r;
    logic       is_i;
    logic       is_lw;
    logic       is_sw;
    logic       is_br;
    logic       is_legal;
    logic [3:0] alu_op;
    logic       unused_ir;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign funct7    = ir[31:25];
    // Register and immediate fields are the datapath's business.
    assign unused_ir = ^{ir[24:15], ir[11:7]};

    // Instruction class; each flag implies the instruction is legal.
    always_comb begin
        is_r  = 1'b0;
        if (opcode == OP_R && funct3 != 3'b011) begin
            if (funct7 == 7'b0000000)
                is_r = 1'b1;
            else if (funct7 == 7'b0100000)
                is_r = (funct3 == 3'b000) || (funct3 == 3'b101);
        end
        is_i  = (opcode == OP_I) && (funct3 != 3'b011);
        is_lw = (opcode == OP_LW) && (funct3 == 3'b010);
        is_sw = (opcode == OP_SW) && (funct3 == 3'b010);
        is_br = (opcode == OP_BR) && (funct3[2:1] == 2'b00);
        is_legal = is_r | is_i | is_lw | is_sw | is_br;
    end

    // IR[30] picks SUB only for R-type; for I-ALU it is immediate data.
    always_comb begin
        unique case (funct3)
            3'b000:  alu_op = (is_r && ir[30]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = ir[30] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        ALUCtrl = ALU_ADD;
        unique case (1'b1)
            is_r, is_i: ALUCtrl = alu_op;
            is_br:      ALUCtrl = ALU_SUB;
            default:    ALUCtrl = ALU_ADD;
        endcase
    end

    assign ALUSrc       = is_i | is_lw | is_sw;
    assign MemtoReg     = is_lw;
    assign IllegalInstr = illegal_q;
    assign ctrlState    = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FETCH;
            ir        <= INSTR_RESET;
            illegal_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_FETCH && iValid)
                ir <= instruction;
            if (state == S_DECODE && !is_legal)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_FETCH:   if (iValid) state_n = S_DECODE;
            S_DECODE:  state_n = is_legal ? S_EXECUTE : S_ERROR;
            S_EXECUTE: state_n = (is_lw | is_sw) ? S_MEM : S_FETCH;
            S_MEM:     if (dReady) state_n = S_FETCH;
            S_ERROR:   state_n = S_ERROR;
            default:   state_n = S_ERROR;
        endcase
    end

    always_comb begin
        iReq     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        loadPC   = 1'b0;
        PCSrc    = 1'b0;
        RegWrite = 1'b0;
        unique case (state)
            S_FETCH: iReq = 1'b1;
            S_EXECUTE: begin
                if (is_r | is_i) begin
                    RegWrite = 1'b1;
                    loadPC   = 1'b1;
                end
                if (is_br) begin
                    loadPC = 1'b1;
                    // funct3[0] distinguishes BNE from BEQ.
                    PCSrc  = funct3[0] ? ~Zero : Zero;
                end
            end
            S_MEM: begin
                MemRead  = is_lw;
                MemWrite = is_sw;
                if (dReady && (is_lw | is_sw)) begin
                    loadPC   = 1'b1;
                    RegWrite = is_lw;
                end
            end
            default: ;
        endcase
    end

`ifdef RETIRE_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            instret <= 32'd0;
        else if (loadPC)
            instret <= instret + 32'd1;
    end
`endif

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// tb_riscv_multicycle_control: directed bench for riscv_multicycle_control
// with an instruction-level trace model and a per-cycle compare process.
module tb_riscv_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        iValid;
    logic        dReady;
    logic        Zero;
    logic        iReq;
    logic        MemRead;
    logic        MemWrite;
    logic        loadPC;
    logic        PCSrc;
    logic        ALUSrc;
    logic        RegWrite;
    logic        MemtoReg;
    logic [3:0]  ALUCtrl;
    logic        IllegalInstr;
    logic [2:0]  ctrlState;
`ifdef RETIRE_COUNT_EN
    logic [31:0] instret;
`endif

    riscv_multicycle_control dut (
        .clk(clk),
        .rst(rst),
        .instruction(instruction),
        .iValid(iValid),
        .dReady(dReady),
        .Zero(Zero),
        .iReq(iReq),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .loadPC(loadPC),
        .PCSrc(PCSrc),
        .ALUSrc(ALUSrc),
        .RegWrite(RegWrite),
        .MemtoReg(MemtoReg),
        .ALUCtrl(ALUCtrl),
        .IllegalInstr(IllegalInstr),
`ifdef RETIRE_COUNT_EN
        .instret(instret),
`endif
        .ctrlState(ctrlState)
    );

    always #5 clk = ~clk;

    localparam int C_BAD = 0;
    localparam int C_R   = 1;
    localparam int C_I   = 2;
    localparam int C_LW  = 3;
    localparam int C_SW  = 4;
    localparam int C_BEQ = 5;
    localparam int C_BNE = 6;

    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_SLT = 4'b0111;
    localparam logic [3:0] A_SRL = 4'b1000;
    localparam logic [3:0] A_SLL = 4'b1001;
    localparam logic [3:0] A_SRA = 4'b1010;
    localparam logic [3:0] A_XOR = 4'b1101;

    typedef struct packed {
        logic        ireq;
        logic        mrd;
        logic        mwr;
        logic        lpc;
        logic        pcs;
        logic        asrc;
        logic        rw;
        logic        m2r;
        logic        ill;
        logic        chk_alu;
        logic [3:0]  alu;
        logic [2:0]  st;
        logic [31:0] iret;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        ce;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_lpc = 0;
    int          n_mr = 0;
    int          n_mw = 0;
    int          n_rw = 0;
    int          n_lpc = 0;
    logic [3:0]  ex_alu = 4'h0;
    logic        ex_asrc = 1'b0;
    logic        ex_pcs = 1'b0;
    logic [31:0] ir_m;
    logic [31:0] iret_m;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got %0h required %0h", nm, $time, act, req);
        end
    endtask

    function automatic int classify(input logic [31:0] w);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = w[14:12];
        f7 = w[31:25];
        case (w[6:0])
            7'h33: begin
                if (f3 == 3'd3) return C_BAD;
                if (f7 == 7'h00) return C_R;
                if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return C_R;
                return C_BAD;
            end
            7'h13: return (f3 == 3'd3) ? C_BAD : C_I;
            7'h03: return (f3 == 3'd2) ? C_LW : C_BAD;
            7'h23: return (f3 == 3'd2) ? C_SW : C_BAD;
            7'h63: begin
                if (f3 == 3'd0) return C_BEQ;
                if (f3 == 3'd1) return C_BNE;
                return C_BAD;
            end
            default: return C_BAD;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [31:0] w);
        int c;
        logic [2:0] f3;
        c  = classify(w);
        f3 = w[14:12];
        if (c == C_LW || c == C_SW) return A_ADD;
        if (c == C_BEQ || c == C_BNE) return A_SUB;
        if (c == C_R || c == C_I) begin
            case (f3)
                3'd0:    return (c == C_R && w[30]) ? A_SUB : A_ADD;
                3'd1:    return A_SLL;
                3'd2:    return A_SLT;
                3'd4:    return A_XOR;
                3'd5:    return w[30] ? A_SRA : A_SRL;
                3'd6:    return A_OR;
                default: return A_AND;
            endcase
        end
        return A_ADD;
    endfunction

    // Expected outputs for a cycle spent in state st with the model IR.
    function automatic exp_t mk(input logic [2:0] st);
        exp_t e;
        int   c;
        c         = classify(ir_m);
        e         = '0;
        e.st      = st;
        e.iret    = iret_m;
        e.chk_alu = (c != C_BAD);
        e.alu     = alu_of(ir_m);
        e.asrc    = (c == C_I || c == C_LW || c == C_SW);
        e.m2r     = (c == C_LW);
        e.ill     = (st == 3'd7);
        e.ireq    = (st == 3'd0);
        return e;
    endfunction

    task automatic step(input exp_t e);
        exp_q.push_back(e);
        if (e.lpc) iret_m = iret_m + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        ir_m   = 32'h00000013;
        iret_m = 32'd0;
    endtask

    task automatic run_instr(input logic [31:0] w, input int fw,
                             input int mw, input logic z);
        exp_t e;
        int   c;
        c    = classify(w);
        Zero = z;
        for (int k = 0; k < fw; k++) begin
            iValid = 1'b0;
            instruction = 32'hFFFFFFFF;
            dReady = 1'b1;
            step(mk(3'd0));
        end
        iValid = 1'b1;
        instruction = w;
        dReady = 1'b1;
        step(mk(3'd0));
        ir_m = w;
        instruction = 32'hFFFFFFFF;
        step(mk(3'd1));
        if (c == C_BAD) begin
            for (int k = 0; k < 10; k++) step(mk(3'd7));
            return;
        end
        iValid = 1'b0;
        e = mk(3'd2);
        case (c)
            C_R, C_I: begin
                e.rw  = 1'b1;
                e.lpc = 1'b1;
            end
            C_BEQ: begin
                e.lpc = 1'b1;
                e.pcs = z;
            end
            C_BNE: begin
                e.lpc = 1'b1;
                e.pcs = !z;
            end
            default: ;
        endcase
        step(e);
        if (c == C_LW || c == C_SW) begin
            for (int k = 0; k < mw; k++) begin
                dReady = 1'b0;
                e = mk(3'd3);
                e.mrd = (c == C_LW);
                e.mwr = (c == C_SW);
                step(e);
            end
            dReady = 1'b1;
            e = mk(3'd3);
            e.mrd = (c == C_LW);
            e.mwr = (c == C_SW);
            e.lpc = 1'b1;
            e.rw  = (c == C_LW);
            step(e);
        end
        iValid = 1'b0;
        dReady = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            ce = exp_q.pop_front();
            cyc++;
            chk("ctrlState", ctrlState, ce.st);
            chk("iReq", iReq, ce.ireq);
            chk("MemRead", MemRead, ce.mrd);
            chk("MemWrite", MemWrite, ce.mwr);
            chk("loadPC", loadPC, ce.lpc);
            chk("PCSrc", PCSrc, ce.pcs);
            chk("RegWrite", RegWrite, ce.rw);
            chk("IllegalInstr", IllegalInstr, ce.ill);
            if (ce.chk_alu) begin
                chk("ALUCtrl", ALUCtrl, ce.alu);
                chk("ALUSrc", ALUSrc, ce.asrc);
                chk("MemtoReg", MemtoReg, ce.m2r);
            end
`ifdef RETIRE_COUNT_EN
            chk("instret", instret, ce.iret);
`endif
            if (loadPC === 1'b1) begin
                n_lpc++;
                last_lpc = cyc;
            end
            if (MemRead === 1'b1) n_mr++;
            if (MemWrite === 1'b1) n_mw++;
            if (RegWrite === 1'b1) n_rw++;
            if (ctrlState === 3'd2) begin
                ex_alu  = ALUCtrl;
                ex_asrc = ALUSrc;
                ex_pcs  = PCSrc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   s;
        int   a;
        exp_t e;
        rst = 1'b0;
        iValid = 1'b1;
        instruction = 32'h00500093;
        dReady = 1'b1;
        Zero = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) step(mk(3'd0));
        rst = 1'b1;

        s = cyc;
        run_instr(32'h00500093, 0, 0, 1'b0);
        chk("addi_latency", last_lpc - s, 3);
        chk("addi_alu", ex_alu, 4'b0010);
        chk("addi_alusrc", ex_asrc, 1'b1);

        s = cyc;
        run_instr(32'h002081B3, 1, 0, 1'b0);
        chk("add_latency", last_lpc - s, 4);
        chk("add_alu", ex_alu, 4'b0010);
        chk("add_alusrc", ex_asrc, 1'b0);
        run_instr(32'h402081B3, 0, 0, 1'b0);
        chk("sub_alu", ex_alu, 4'b0110);
        run_instr(32'h0FF0C093, 0, 0, 1'b0);
        run_instr(32'h4030D093, 2, 0, 1'b1);
        chk("srai_alu", ex_alu, 4'b1010);
        run_instr(32'h0020F1B3, 0, 0, 1'b0);
        run_instr(32'h0020A1B3, 0, 0, 1'b0);

        s = cyc;
        a = n_mr;
        run_instr(32'h0040A283, 0, 2, 1'b0);
        chk("lw_latency", last_lpc - s, 6);
        chk("lw_memread_cycles", n_mr - a, 3);
        s = n_mw;
        a = n_rw;
        run_instr(32'h0020A423, 0, 2, 1'b0);
        chk("sw_memwrite_cycles", n_mw - s, 3);
        chk("sw_regwrite_cycles", n_rw - a, 0);
        s = cyc;
        run_instr(32'h0040A283, 0, 0, 1'b1);
        chk("lw_fast_latency", last_lpc - s, 4);

        run_instr(32'h00208463, 0, 0, 1'b1);
        chk("beq_z1_pcsrc", ex_pcs, 1'b1);
        run_instr(32'h00208463, 0, 0, 1'b0);
        chk("beq_z0_pcsrc", ex_pcs, 1'b0);
        run_instr(32'h00209463, 0, 0, 1'b1);
        chk("bne_z1_pcsrc", ex_pcs, 1'b0);
        run_instr(32'h00209463, 0, 0, 1'b0);
        chk("bne_z0_pcsrc", ex_pcs, 1'b1);

        s = n_lpc;
        run_instr(32'hFFFFFFFF, 0, 0, 1'b1);
        chk("illegal_flag", IllegalInstr, 1'b1);
        chk("illegal_state", ctrlState, 3'd7);
        chk("illegal_no_retire", n_lpc - s, 0);
        rst = 1'b0;
        model_reset();
        step(mk(3'd0));
        rst = 1'b1;
        chk("illegal_cleared", IllegalInstr, 1'b0);
        chk("illegal_to_fetch", ctrlState, 3'd0);

        run_instr(32'h402091B3, 1, 0, 1'b0);
        chk("sub_f3_illegal", IllegalInstr, 1'b1);
        rst = 1'b0;
        model_reset();
        step(mk(3'd0));
        rst = 1'b1;
        run_instr(32'h00500093, 0, 0, 1'b0);

        Zero = 1'b0;
        iValid = 1'b1;
        instruction = 32'h0040A283;
        dReady = 1'b0;
        step(mk(3'd0));
        ir_m = 32'h0040A283;
        iValid = 1'b0;
        step(mk(3'd1));
        step(mk(3'd2));
        e = mk(3'd3);
        e.mrd = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
        s = n_lpc;
        rst = 1'b0;
        #1;
        chk("abort_memread", MemRead, 1'b0);
        chk("abort_regwrite", RegWrite, 1'b0);
        chk("abort_loadpc", loadPC, 1'b0);
        chk("abort_state", ctrlState, 3'd0);
`ifdef RETIRE_COUNT_EN
        chk("abort_instret", instret, 32'd0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        dReady = 1'b1;
        step(mk(3'd0));
        step(mk(3'd0));
        chk("abort_no_retire", n_lpc - s, 0);
        rst = 1'b1;
        run_instr(32'h002081B3, 0, 0, 1'b0);
`ifdef RETIRE_COUNT_EN
        chk("instret_after_abort", instret, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
